neuron_sched: RTL and testbench
===============================

NEURON_SCHED -- requirements
Module: neuron_sched

Interface
REQ-001 Parameter N_NEUR, default 256, number of post-synaptic neurons; SHALL be a power of two.
REQ-002 Parameter N_ADDR, default 8, neuron address width, equal to log2(N_NEUR).
REQ-003 CLK  in  1  single clock; all state SHALL change on its rising edge only.
REQ-004 RSTN  in  1  reset; asynchronous and active-low.
REQ-005 sched_en  in  1  when low, no new event SHALL be accepted; an event already in progress SHALL complete.
REQ-006 evt_req  in  1  event request.
REQ-007 evt_addr  in  N_ADDR  pre-synaptic source address.
REQ-008 evt_tref  in  1  1 = time-reference (leak) event, 0 = synaptic event.
REQ-009 evt_ack  out  1  one-cycle acceptance pulse.
REQ-010 busy  out  1  high from the cycle after acceptance until the last neuron is written.
REQ-011 nrn_cs, nrn_we  out  1 each  neuron SRAM chip select and write enable.
REQ-012 nrn_addr  out  N_ADDR  neuron SRAM address.
REQ-013 nrn_wdata  out  32  neuron word: [11:0] state, [23:12] thr, [30:24] leak, [31] disable.
REQ-014 nrn_rdata  in  32  read data, valid one cycle after a read.
REQ-015 syn_cs  out  1  synapse SRAM read select.
REQ-016 syn_addr  out  N_ADDR+N_ADDR-3  {pre[7:0], post[7:3]}; 8 x 4-bit weights per word.
REQ-017 syn_rdata  in  32  read data, valid one cycle after a read.
REQ-018 spk_valid  out  1  and spk_ready  in  1  form the output spike handshake.
REQ-019 spk_addr  out  N_ADDR  address of the neuron that fired.

Function
REQ-020 States SHALL be IDLE, RD, LAT, WR.
REQ-021 IDLE: evt_req & sched_en SHALL pulse evt_ack, latch evt_addr/evt_tref, clear neuron counter j to 0, and go to RD.
REQ-022 RD: nrn_cs=1, nrn_we=0, nrn_addr=j; syn_cs = ~tref, syn_addr={pre, j[7:3]}; go to LAT.
REQ-023 LAT: nrn_rdata and syn_rdata SHALL be captured into holding registers; SRAM selects low; go to WR.
REQ-024 WR: held values SHALL drive one lif_neuron_charge instance with syn_event=1, time_ref=tref, weight=syn_word[4*j[2:0]+3 : 4*j[2:0]], leak/thr/state from the neuron word.
REQ-025 WR: a write SHALL be issued (nrn_cs=nrn_we=1, nrn_addr=j), with wdata = held word with [11:0] replaced by state_core_next.
REQ-026 A disabled neuron (bit 31 = 1) SHALL be neither written nor allowed to spike; its WR SHALL last one cycle with all selects low.
REQ-027 A spike in WR SHALL load spk_addr=j and set spk_valid, but only if the output register is empty or draining (spk_ready high) that cycle.
REQ-028 Otherwise FSM SHALL stay in WR with no SRAM access until the spike can be loaded; write and spike load SHALL occur in the same cycle.
REQ-029 spk_valid SHALL hold with spk_addr stable until spk_ready; a spike SHALL never be dropped or duplicated.
REQ-030 After WR, if j = N_NEUR-1 go to IDLE, else increment j and go to RD; a non-stalled event takes exactly 3*N_NEUR cycles after acceptance.
REQ-031 evt_req asserted while busy SHALL be ignored until IDLE; acceptance SHALL be possible in the first IDLE cycle after completion.
REQ-032 Leak events SHALL not read synapse SRAM (syn_cs=0 throughout).

Reset
REQ-033 On RSTN low: state=IDLE, j=0, holding regs=0, spk_valid=0, spk_addr=0, evt_ack=0, busy=0, all SRAM selects 0 -- immediately, including mid-event; no partial write SHALL be issued after reset asserts.

Structure
REQ-034 A shared package SHALL hold the FSM state enum, the neuron-word field bit positions, and the syn-word weight width (4).
REQ-035 The block SHALL instantiate exactly one lif_neuron_charge sub-module; no other sub-modules.

Verification
REQ-036 Synaptic event pre=0x05, neuron 3 state=100, thr=200, weight nibble=+7 -> neuron 3 written with state 107, no spike, evt_ack one pulse, done 768 cycles later.
REQ-037 Neuron 9 state=195, thr=200, weight=+7 -> spk_valid with spk_addr=0x09, neuron 9 written state 0.
REQ-038 Leak event with state=10, leak=4 for all neurons -> all states 6, syn_cs never high, no spikes.
REQ-039 Two consecutive spiking neurons with spk_ready held low for 20 cycles -> FSM stalls in WR, no SRAM access during stall, both spikes delivered in order.
REQ-040 RSTN pulsed low at neuron 100 of an event -> all outputs zero at once, next evt_req accepted from IDLE with j=0.
REQ-041 sched_en=0 with evt_req=1 -> no evt_ack; raising sched_en -> ack on the next cycle.

Source files
------------

// File: rtl/neuron_sched_pkg.sv
// Shared types and field layout for the neuron event scheduler.
package neuron_sched_pkg;

  // Scheduler FSM states
  typedef enum logic [1:0] {
    SCH_IDLE = 2'd0,
    SCH_RD   = 2'd1,
    SCH_LAT  = 2'd2,
    SCH_WR   = 2'd3
  } sched_state_e;

  // Neuron SRAM word layout
  localparam int WORD_W        = 32;
  localparam int NRN_STATE_LSB = 0;
  localparam int NRN_STATE_W   = 12;
  localparam int NRN_THR_LSB   = 12;
  localparam int NRN_THR_W     = 12;
  localparam int NRN_LEAK_LSB  = 24;
  localparam int NRN_LEAK_W    = 7;
  localparam int NRN_DIS_BIT   = 31;

  // Synapse SRAM word layout: eight signed 4-bit weights per word
  localparam int SYN_WEIGHT_W         = 4;
  localparam int SYN_WEIGHTS_PER_WORD = 8;

  // Replace the membrane state field of a neuron word, keeping all other fields
  function automatic logic [WORD_W-1:0] nrn_set_state(input logic [WORD_W-1:0] word,
                                                      input logic [NRN_STATE_W-1:0] state);
    logic [WORD_W-1:0] w_res;
    w_res = word;
    w_res[NRN_STATE_LSB +: NRN_STATE_W] = state;
    return w_res;
  endfunction

endpackage

// File: rtl/neuron_sched_if.sv
// Event, SRAM and spike-output signals of the neuron scheduler.
// master = scheduler view, slave = environment (event source, SRAMs, spike sink).
interface neuron_sched_if
  import neuron_sched_pkg::*;
#(
  parameter int N_ADDR = 8
);
  // event input
  logic                  sched_en;
  logic                  evt_req;
  logic [N_ADDR-1:0]     evt_addr;
  logic                  evt_tref;
  logic                  evt_ack;
  logic                  busy;
  // neuron SRAM
  logic                  nrn_cs;
  logic                  nrn_we;
  logic [N_ADDR-1:0]     nrn_addr;
  logic [WORD_W-1:0]     nrn_wdata;
  logic [WORD_W-1:0]     nrn_rdata;
  // synapse SRAM
  logic                  syn_cs;
  logic [2*N_ADDR-4:0]   syn_addr;
  logic [WORD_W-1:0]     syn_rdata;
  // spike output
  logic                  spk_valid;
  logic                  spk_ready;
  logic [N_ADDR-1:0]     spk_addr;

  modport master (
    input  sched_en, evt_req, evt_addr, evt_tref, nrn_rdata, syn_rdata, spk_ready,
    output evt_ack, busy, nrn_cs, nrn_we, nrn_addr, nrn_wdata, syn_cs, syn_addr,
           spk_valid, spk_addr
  );

  modport slave (
    output sched_en, evt_req, evt_addr, evt_tref, nrn_rdata, syn_rdata, spk_ready,
    input  evt_ack, busy, nrn_cs, nrn_we, nrn_addr, nrn_wdata, syn_cs, syn_addr,
           spk_valid, spk_addr
  );

endinterface

// File: rtl/neuron_sched_charge.sv
// Leaky integrate-and-fire update of one neuron's membrane state.
// Leak events subtract the leak (floor 0); synaptic events add a signed
// 4-bit weight with saturation and fire (reset to 0) at or above threshold.
module lif_neuron_charge
  import neuron_sched_pkg::*;
(
  input  logic                    i_syn_event,
  input  logic                    i_time_ref,
  input  logic [SYN_WEIGHT_W-1:0] i_weight,
  input  logic [NRN_LEAK_W-1:0]   i_leak,
  input  logic [NRN_THR_W-1:0]    i_thr,
  input  logic [NRN_STATE_W-1:0]  i_state,
  output logic [NRN_STATE_W-1:0]  o_state_core_next,
  output logic                    o_spike
);

  logic signed [NRN_STATE_W+1:0] w_sum;
  logic [NRN_STATE_W-1:0]        w_sat;
  logic [NRN_STATE_W-1:0]        w_leak_ext;

  assign w_sum = $signed({2'b00, i_state}) +
                 $signed({{(NRN_STATE_W+2-SYN_WEIGHT_W){i_weight[SYN_WEIGHT_W-1]}}, i_weight});
  assign w_leak_ext = {{(NRN_STATE_W-NRN_LEAK_W){1'b0}}, i_leak};

  // Saturate the integrated value into the unsigned state range
  always_comb begin
    w_sat = w_sum[NRN_STATE_W-1:0];
    if (w_sum[NRN_STATE_W+1]) begin
      w_sat = '0;
    end else if (w_sum[NRN_STATE_W]) begin
      w_sat = '1;
    end
  end

  // Select leak or integrate-and-fire result
  always_comb begin
    o_state_core_next = i_state;
    o_spike           = 1'b0;
    if (i_time_ref) begin
      o_state_core_next = (i_state > w_leak_ext) ? (i_state - w_leak_ext) : '0;
    end else if (i_syn_event) begin
      if (w_sat >= i_thr) begin
        o_spike           = 1'b1;
        o_state_core_next = '0;
      end else begin
        o_state_core_next = w_sat;
      end
    end
  end

endmodule

// File: rtl/neuron_sched.sv
// Event scheduler: for each accepted event, sweeps all post-synaptic neurons
// with a read / latch / write-back sequence and emits spikes on a
// valid/ready output that never drops or duplicates a spike.
module neuron_sched
  import neuron_sched_pkg::*;
#(
  parameter int N_NEUR = 256,
  parameter int N_ADDR = 8
)(
  input  logic           i_clk,
  input  logic           i_rstn,
  neuron_sched_if.master sif
);

  localparam logic [1:0] ST_IDLE = SCH_IDLE;
  localparam logic [1:0] ST_RD   = SCH_RD;
  localparam logic [1:0] ST_LAT  = SCH_LAT;
  localparam logic [1:0] ST_WR   = SCH_WR;

  logic [1:0]          r_state;
  logic [N_ADDR-1:0]   r_j;
  logic [N_ADDR-1:0]   r_pre;
  logic                r_tref;
  logic [WORD_W-1:0]   r_nrn_word;
  logic [WORD_W-1:0]   r_syn_word;
  logic                r_evt_ack;
  logic                r_busy;
  logic                r_spk_valid;
  logic [N_ADDR-1:0]   r_spk_addr;

  logic                    w_accept;
  logic                    w_disabled;
  logic                    w_core_spike;
  logic                    w_spike;
  logic                    w_can_load;
  logic                    w_stall;
  logic                    w_wr_go;
  logic                    w_write;
  logic                    w_spk_load;
  logic                    w_last;
  logic [SYN_WEIGHT_W-1:0] w_weight;
  logic [NRN_STATE_W-1:0]  w_state_core_next;
  logic [SYN_WEIGHT_W-1:0] w_nibble [SYN_WEIGHTS_PER_WORD];

  // Split the held synapse word into its per-neuron weights
  genvar gi;
  generate
    for (gi = 0; gi < SYN_WEIGHTS_PER_WORD; gi++) begin : g_nibble
      assign w_nibble[gi] = r_syn_word[gi*SYN_WEIGHT_W +: SYN_WEIGHT_W];
    end
  endgenerate

  assign w_weight = w_nibble[r_j[2:0]];

  lif_neuron_charge u_charge (
    .i_syn_event       (1'b1),
    .i_time_ref        (r_tref),
    .i_weight          (w_weight),
    .i_leak            (r_nrn_word[NRN_LEAK_LSB +: NRN_LEAK_W]),
    .i_thr             (r_nrn_word[NRN_THR_LSB +: NRN_THR_W]),
    .i_state           (r_nrn_word[NRN_STATE_LSB +: NRN_STATE_W]),
    .o_state_core_next (w_state_core_next),
    .o_spike           (w_core_spike)
  );

  // A write-back cycle may only complete when its spike (if any) can enter
  // the output register; otherwise it repeats with all SRAM selects low.
  assign w_accept   = (r_state == ST_IDLE) & sif.evt_req & sif.sched_en;
  assign w_disabled = r_nrn_word[NRN_DIS_BIT];
  assign w_spike    = w_core_spike & ~w_disabled;
  assign w_can_load = ~r_spk_valid | sif.spk_ready;
  assign w_stall    = (r_state == ST_WR) & w_spike & ~w_can_load;
  assign w_wr_go    = (r_state == ST_WR) & ~w_stall;
  assign w_write    = w_wr_go & ~w_disabled;
  assign w_spk_load = w_wr_go & w_spike;
  assign w_last     = (r_j == N_ADDR'(N_NEUR - 1));

  assign sif.evt_ack   = r_evt_ack;
  assign sif.busy      = r_busy;
  assign sif.nrn_cs    = (r_state == ST_RD) | w_write;
  assign sif.nrn_we    = w_write;
  assign sif.nrn_addr  = r_j;
  assign sif.nrn_wdata = nrn_set_state(r_nrn_word, w_state_core_next);
  assign sif.syn_cs    = (r_state == ST_RD) & ~r_tref;
  assign sif.syn_addr  = {r_pre, r_j[N_ADDR-1:3]};
  assign sif.spk_valid = r_spk_valid;
  assign sif.spk_addr  = r_spk_addr;

  // Sequencer: event latch, neuron counter and SRAM read holding registers
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state    <= ST_IDLE;
      r_j        <= '0;
      r_pre      <= '0;
      r_tref     <= 1'b0;
      r_nrn_word <= '0;
      r_syn_word <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_pre   <= sif.evt_addr;
            r_tref  <= sif.evt_tref;
            r_j     <= '0;
            r_state <= ST_RD;
          end
        end
        ST_RD: begin
          r_state <= ST_LAT;
        end
        ST_LAT: begin
          r_nrn_word <= sif.nrn_rdata;
          r_syn_word <= r_tref ? '0 : sif.syn_rdata;
          r_state    <= ST_WR;
        end
        ST_WR: begin
          if (w_wr_go) begin
            if (w_last) begin
              r_state <= ST_IDLE;
            end else begin
              r_j     <= r_j + N_ADDR'(1);
              r_state <= ST_RD;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Acceptance pulse and busy flag spanning the whole neuron sweep
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_evt_ack <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_evt_ack <= w_accept;
      if (w_accept) begin
        r_busy <= 1'b1;
      end else if (w_wr_go && w_last) begin
        r_busy <= 1'b0;
      end
    end
  end

  // Spike output register: a new load takes priority over the drain
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_spk_valid <= 1'b0;
      r_spk_addr  <= '0;
    end else begin
      if (w_spk_load) begin
        r_spk_valid <= 1'b1;
        r_spk_addr  <= r_j;
      end else if (r_spk_valid && sif.spk_ready) begin
        r_spk_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_neuron_sched.sv
// Directed self-checking bench for neuron_sched with behavioural SRAM models.
module tb_neuron_sched;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  neuron_sched_if #(.N_ADDR(8)) sif ();

  neuron_sched #(.N_NEUR(256), .N_ADDR(8)) dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .sif    (sif)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // memories, counters and spike log are written only by the model process
  logic [31:0] nmem [256];
  logic [31:0] smem [8192];
  int          wr_cnt = 0;
  int          syn_cs_cnt = 0;
  int          ack_cnt = 0;
  logic [7:0]  spk_q [$];

  // preload request, written only by the stimulus process
  logic        ld_go = 1'b0;
  logic [31:0] ld_nfill;
  logic [31:0] ld_sfill;
  logic        ov_n_en [4];
  int          ov_n_idx [4];
  logic [31:0] ov_n_word [4];
  logic        ov_s_en [2];
  int          ov_s_idx [2];
  logic [31:0] ov_s_word [2];

  function automatic logic [31:0] nw(input bit dis, input int leak, input int thr, input int st);
    return {dis, 7'(leak), 12'(thr), 12'(st)};
  endfunction

  always @(posedge clk) begin
    if (ld_go) begin
      for (int i = 0; i < 256; i++) nmem[i] = ld_nfill;
      for (int i = 0; i < 8192; i++) smem[i] = ld_sfill;
      for (int k = 0; k < 4; k++) if (ov_n_en[k]) nmem[ov_n_idx[k]] = ov_n_word[k];
      for (int k = 0; k < 2; k++) if (ov_s_en[k]) smem[ov_s_idx[k]] = ov_s_word[k];
    end
    if (sif.nrn_cs && sif.nrn_we) begin
      nmem[sif.nrn_addr] = sif.nrn_wdata;
      wr_cnt++;
    end
    if (sif.nrn_cs && !sif.nrn_we) sif.nrn_rdata <= nmem[sif.nrn_addr];
    if (sif.syn_cs) begin
      sif.syn_rdata <= smem[sif.syn_addr];
      syn_cs_cnt++;
    end
    if (sif.spk_valid && sif.spk_ready) spk_q.push_back(sif.spk_addr);
    if (sif.evt_ack) ack_cnt++;
  end

  task automatic clear_ov();
    for (int k = 0; k < 4; k++) ov_n_en[k] = 1'b0;
    for (int k = 0; k < 2; k++) ov_s_en[k] = 1'b0;
  endtask

  task automatic do_load();
    ld_go = 1'b1;
    @(posedge clk);
    #1 ld_go = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_ack(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (sif.evt_ack) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (sif.busy && cyc < 4000) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    sif.sched_en = 1'b0; sif.evt_req = 1'b0; sif.evt_addr = '0;
    sif.evt_tref = 1'b0; sif.spk_ready = 1'b1;
    clear_ov();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({sif.evt_ack, sif.busy, sif.nrn_cs, sif.nrn_we, sif.syn_cs, sif.spk_valid} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 000000",
               {sif.evt_ack, sif.busy, sif.nrn_cs, sif.nrn_we, sif.syn_cs, sif.spk_valid});
    end
    n_checks++;
    if (sif.spk_addr !== 8'h00) begin
      n_fail++; $display("FAIL reset_spk_addr: got %h expected 00", sif.spk_addr);
    end
    n_checks++;
    if (sif.nrn_addr !== 8'h00) begin
      n_fail++; $display("FAIL reset_nrn_addr: got %h expected 00", sif.nrn_addr);
    end
    rstn = 1'b1;
    sif.sched_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_syn_event();
    int c, b, wr0, syn0, ack0, q0;
    clear_ov();
    ld_nfill = nw(0, 0, 200, 0); ld_sfill = 32'h0;
    ov_n_en[0] = 1; ov_n_idx[0] = 3;  ov_n_word[0] = nw(0, 0, 200, 100);
    ov_n_en[1] = 1; ov_n_idx[1] = 9;  ov_n_word[1] = nw(0, 0, 200, 195);
    ov_n_en[2] = 1; ov_n_idx[2] = 12; ov_n_word[2] = nw(1, 0, 200, 195);
    ov_s_en[0] = 1; ov_s_idx[0] = 160; ov_s_word[0] = 32'h0000_7000;
    ov_s_en[1] = 1; ov_s_idx[1] = 161; ov_s_word[1] = 32'h0007_0070;
    do_load();
    sif.spk_ready = 1'b1;
    wr0 = wr_cnt; syn0 = syn_cs_cnt; ack0 = ack_cnt; q0 = spk_q.size();
    sif.evt_addr = 8'h05; sif.evt_tref = 1'b0; sif.evt_req = 1'b1;
    wait_ack(c);
    sif.evt_req = 1'b0;
    n_checks++;
    if (c !== 1) begin n_fail++; $display("FAIL syn_ack_latency: got %0d expected 1", c); end
    n_checks++;
    if (sif.busy !== 1'b1) begin n_fail++; $display("FAIL syn_busy_after_ack: got %b expected 1", sif.busy); end
    wait_idle(b);
    n_checks++;
    if (b !== 768) begin n_fail++; $display("FAIL syn_busy_cycles: got %0d expected 768", b); end
    repeat (2) @(negedge clk);
    n_checks++;
    if (ack_cnt - ack0 !== 1) begin n_fail++; $display("FAIL syn_ack_pulses: got %0d expected 1", ack_cnt - ack0); end
    n_checks++;
    if (nmem[3] !== nw(0, 0, 200, 107)) begin n_fail++; $display("FAIL syn_n3_word: got %h expected %h", nmem[3], nw(0, 0, 200, 107)); end
    n_checks++;
    if (nmem[9] !== nw(0, 0, 200, 0)) begin n_fail++; $display("FAIL syn_n9_word: got %h expected %h", nmem[9], nw(0, 0, 200, 0)); end
    n_checks++;
    if (nmem[12] !== nw(1, 0, 200, 195)) begin n_fail++; $display("FAIL syn_n12_disabled: got %h expected %h", nmem[12], nw(1, 0, 200, 195)); end
    n_checks++;
    if (wr_cnt - wr0 !== 255) begin n_fail++; $display("FAIL syn_write_count: got %0d expected 255", wr_cnt - wr0); end
    n_checks++;
    if (syn_cs_cnt - syn0 !== 256) begin n_fail++; $display("FAIL syn_read_count: got %0d expected 256", syn_cs_cnt - syn0); end
    n_checks++;
    if (spk_q.size() - q0 !== 1) begin
      n_fail++; $display("FAIL syn_spike_count: got %0d expected 1", spk_q.size() - q0);
    end else begin
      n_checks++;
      if (spk_q[q0] !== 8'h09) begin n_fail++; $display("FAIL syn_spike_addr: got %h expected 09", spk_q[q0]); end
    end
    $display("syn event pre=05: busy=%0d n3=%h n9=%h spikes=%0d", b, nmem[3], nmem[9], spk_q.size() - q0);
  endtask

  task automatic test_leak_event();
    int c, b, wr0, syn0, q0, bad;
    clear_ov();
    ld_nfill = nw(0, 4, 200, 10); ld_sfill = 32'hFFFF_FFFF;
    do_load();
    wr0 = wr_cnt; syn0 = syn_cs_cnt; q0 = spk_q.size();
    sif.evt_addr = 8'h33; sif.evt_tref = 1'b1; sif.evt_req = 1'b1;
    wait_ack(c);
    sif.evt_req = 1'b0;
    wait_idle(b);
    @(negedge clk);
    bad = 0;
    for (int i = 0; i < 256; i++) if (nmem[i] !== nw(0, 4, 200, 6)) bad++;
    n_checks++;
    if (b !== 768) begin n_fail++; $display("FAIL leak_busy_cycles: got %0d expected 768", b); end
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL leak_states: got %0d wrong neurons expected 0 (n0=%h)", bad, nmem[0]); end
    n_checks++;
    if (syn_cs_cnt - syn0 !== 0) begin n_fail++; $display("FAIL leak_syn_cs: got %0d expected 0", syn_cs_cnt - syn0); end
    n_checks++;
    if (spk_q.size() - q0 !== 0) begin n_fail++; $display("FAIL leak_spikes: got %0d expected 0", spk_q.size() - q0); end
    n_checks++;
    if (wr_cnt - wr0 !== 256) begin n_fail++; $display("FAIL leak_writes: got %0d expected 256", wr_cnt - wr0); end
    $display("leak event: busy=%0d wrong=%0d syn_reads=%0d", b, bad, syn_cs_cnt - syn0);
  endtask

  task automatic test_stall();
    int c, b, wr0, q0, acc, bad;
    bit found;
    clear_ov();
    ld_nfill = nw(0, 0, 200, 0); ld_sfill = 32'h0;
    ov_n_en[0] = 1; ov_n_idx[0] = 20; ov_n_word[0] = nw(0, 0, 200, 199);
    ov_n_en[1] = 1; ov_n_idx[1] = 21; ov_n_word[1] = nw(0, 0, 200, 199);
    ov_s_en[0] = 1; ov_s_idx[0] = 34; ov_s_word[0] = 32'h0011_0000;
    do_load();
    sif.spk_ready = 1'b0;
    wr0 = wr_cnt; q0 = spk_q.size();
    sif.evt_addr = 8'h01; sif.evt_tref = 1'b0; sif.evt_req = 1'b1;
    wait_ack(c);
    sif.evt_req = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (sif.spk_valid) begin found = 1'b1; break; end
      @(negedge clk);
    end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL stall_first_spike: got none expected spk_valid"); end
    repeat (2) @(negedge clk);
    acc = 0; bad = 0;
    for (int k = 0; k < 18; k++) begin
      if (sif.nrn_cs || sif.syn_cs) acc++;
      if (!sif.spk_valid || sif.spk_addr !== 8'd20 || !sif.busy) bad++;
      @(negedge clk);
    end
    n_checks++;
    if (acc !== 0) begin n_fail++; $display("FAIL stall_sram_access: got %0d cycles expected 0", acc); end
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL stall_spk_hold: got %0d bad cycles expected 0", bad); end
    n_checks++;
    if (spk_q.size() - q0 !== 0) begin n_fail++; $display("FAIL stall_early_spike: got %0d expected 0", spk_q.size() - q0); end
    sif.spk_ready = 1'b1;
    wait_idle(b);
    repeat (2) @(negedge clk);
    n_checks++;
    if (sif.busy !== 1'b0) begin n_fail++; $display("FAIL stall_timeout: busy still %b after %0d cycles", sif.busy, b); end
    n_checks++;
    if (spk_q.size() - q0 !== 2) begin
      n_fail++; $display("FAIL stall_spike_count: got %0d expected 2", spk_q.size() - q0);
    end else begin
      n_checks++;
      if ({spk_q[q0], spk_q[q0+1]} !== {8'd20, 8'd21}) begin
        n_fail++; $display("FAIL stall_spike_order: got %0d,%0d expected 20,21", spk_q[q0], spk_q[q0+1]);
      end
    end
    n_checks++;
    if (nmem[21] !== nw(0, 0, 200, 0)) begin n_fail++; $display("FAIL stall_n21_word: got %h expected %h", nmem[21], nw(0, 0, 200, 0)); end
    n_checks++;
    if (wr_cnt - wr0 !== 256) begin n_fail++; $display("FAIL stall_writes: got %0d expected 256", wr_cnt - wr0); end
    $display("stall event: stall_access=%0d spikes=%0d", acc, spk_q.size() - q0);
  endtask

  task automatic test_reset_mid_event();
    int c, b, wr0, q0;
    bit found;
    clear_ov();
    ld_nfill = nw(0, 0, 200, 0); ld_sfill = 32'h0;
    ov_n_en[0] = 1; ov_n_idx[0] = 50; ov_n_word[0] = nw(0, 0, 200, 199);
    ov_s_en[0] = 1; ov_s_idx[0] = 70; ov_s_word[0] = 32'h0000_0100;
    do_load();
    sif.spk_ready = 1'b0;
    q0 = spk_q.size();
    sif.evt_addr = 8'h02; sif.evt_tref = 1'b0; sif.evt_req = 1'b1;
    wait_ack(c);
    sif.evt_req = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (sif.nrn_cs && !sif.nrn_we && sif.nrn_addr == 8'd100) begin found = 1'b1; break; end
      @(negedge clk);
    end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL rstmid_reach_100: got none expected read of neuron 100"); end
    n_checks++;
    if ({sif.spk_valid, sif.spk_addr} !== {1'b1, 8'd50}) begin
      n_fail++; $display("FAIL rstmid_pending_spike: got v=%b a=%0d expected v=1 a=50", sif.spk_valid, sif.spk_addr);
    end
    #1 rstn = 1'b0;
    wr0 = wr_cnt;
    #1;
    n_checks++;
    if ({sif.evt_ack, sif.busy, sif.nrn_cs, sif.nrn_we, sif.syn_cs, sif.spk_valid, sif.spk_addr} !== 14'b0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got %b expected all zero",
               {sif.evt_ack, sif.busy, sif.nrn_cs, sif.nrn_we, sif.syn_cs, sif.spk_valid, sif.spk_addr});
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (wr_cnt - wr0 !== 0) begin n_fail++; $display("FAIL rstmid_no_write: got %0d expected 0", wr_cnt - wr0); end
    rstn = 1'b1;
    sif.spk_ready = 1'b1;
    @(negedge clk);
    sif.evt_req = 1'b1;
    wait_ack(c);
    sif.evt_req = 1'b0;
    n_checks++;
    if (c !== 1) begin n_fail++; $display("FAIL rstmid_reaccept: got %0d expected 1", c); end
    n_checks++;
    if ({sif.nrn_cs, sif.nrn_we, sif.nrn_addr} !== {1'b1, 1'b0, 8'd0}) begin
      n_fail++; $display("FAIL rstmid_first_read: got cs=%b we=%b a=%0d expected cs=1 we=0 a=0", sif.nrn_cs, sif.nrn_we, sif.nrn_addr);
    end
    wait_idle(b);
    repeat (2) @(negedge clk);
    n_checks++;
    if (b !== 768) begin n_fail++; $display("FAIL rstmid_busy_cycles: got %0d expected 768", b); end
    n_checks++;
    if (nmem[50] !== nw(0, 0, 200, 1)) begin n_fail++; $display("FAIL rstmid_n50_word: got %h expected %h", nmem[50], nw(0, 0, 200, 1)); end
    n_checks++;
    if (spk_q.size() - q0 !== 0) begin n_fail++; $display("FAIL rstmid_spikes: got %0d expected 0", spk_q.size() - q0); end
    $display("reset mid-event: reaccept=%0d busy=%0d n50=%h", c, b, nmem[50]);
  endtask

  task automatic test_sched_en_back_to_back();
    int b, gap, ack0, act;
    clear_ov();
    ld_nfill = nw(0, 0, 200, 0); ld_sfill = 32'h0;
    do_load();
    ack0 = ack_cnt;
    sif.sched_en = 1'b0;
    sif.evt_addr = 8'h00; sif.evt_tref = 1'b1; sif.evt_req = 1'b1;
    act = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (sif.evt_ack || sif.busy) act++;
    end
    n_checks++;
    if (act !== 0) begin n_fail++; $display("FAIL en_low_blocks: got %0d active cycles expected 0", act); end
    sif.sched_en = 1'b1;
    @(negedge clk);
    n_checks++;
    if (sif.evt_ack !== 1'b1) begin n_fail++; $display("FAIL en_rise_ack: got %b expected 1", sif.evt_ack); end
    gap = -1;
    for (int i = 1; i <= 1000; i++) begin
      @(negedge clk);
      if (sif.evt_ack) begin gap = i; break; end
    end
    sif.evt_req = 1'b0;
    n_checks++;
    if (gap !== 769) begin n_fail++; $display("FAIL b2b_ack_gap: got %0d expected 769", gap); end
    wait_idle(b);
    repeat (2) @(negedge clk);
    n_checks++;
    if (b !== 768) begin n_fail++; $display("FAIL b2b_busy_cycles: got %0d expected 768", b); end
    n_checks++;
    if (ack_cnt - ack0 !== 2) begin n_fail++; $display("FAIL b2b_ack_pulses: got %0d expected 2", ack_cnt - ack0); end
    $display("sched_en/back-to-back: gap=%0d acks=%0d", gap, ack_cnt - ack0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_syn_event();
    test_leak_event();
    test_stall();
    test_reset_mid_event();
    test_sched_en_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
